mips_multicycle_sequencer: RTL and testbench

Multi-cycle control FSM for the 32-bit MIPS core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and issues per-state datapath strobes (PC, IR, memory, register file). It waits on a memory ready handshake, times out stalled accesses, and enters interrupt/exception states that save the return PC to $26 and redirect the PC. The ALU-function and extend decode stays in the existing combinational control; this block owns sequencing only.

---
 rtl/mips_multicycle_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_mips_multicycle_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle sequencing FSM for the MIPS core: steps FETCH/DECODE/EXEC/MEM/WB,
// waits on the memory handshake with a bus timeout, and enters INT/EXC states.
module mips_multicycle_sequencer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OpCode,
   input  logic [5:0] Funct,
   input  logic       IRQ,
   input  logic       ker,
   input  logic       mem_ready,
   input  logic       branch_cond,
   output logic       PCWrite,
   output logic [2:0] PCSrc,
   output logic       IorD,
   output logic       IRWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic [2:0] state,
   output logic [1:0] exc_cause,
   output logic       instr_done
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_INT    = 3'd5,
      S_EXC    = 3'd6
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] cause_q, cause_d;
   logic       done;
   logic       is_lw, is_sw, is_branch, timeout_hit;

   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'h00) begin
         case (fn)
            6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h2a: return 1'b1;
            default: return (fn >= 6'h20) && (fn <= 6'h27);
         endcase
      end
      return ((op >= 6'h01) && (op <= 6'h0c)) || (op == 6'h0f) ||
             (op == 6'h23) || (op == 6'h2b);
   endfunction

   assign is_lw       = (OpCode == 6'h23);
   assign is_sw       = (OpCode == 6'h2b);
   assign is_branch   = (OpCode == 6'h01) || ((OpCode >= 6'h04) && (OpCode <= 6'h07));
   assign timeout_hit = !mem_ready && (cnt_q == 8'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      cnt_d      = '0;
      done       = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 3'd0;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 2'd0;
      MemtoReg   = 2'd0;
      instr_done = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               MemRead = 1'b1;
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = S_DECODE;
            end else if (timeout_hit) begin
               state_d = S_EXC;
               cause_d = 2'd2;
            end else begin
               MemRead = 1'b1;
               cnt_d   = cnt_q + 8'd1;
            end
         end
         S_DECODE: begin
            if (!is_legal(OpCode, Funct)) begin
               state_d = S_EXC;
               cause_d = 2'd1;
            end else if (OpCode == 6'h02 || OpCode == 6'h03) begin
               PCWrite = 1'b1;
               PCSrc   = 3'd2;
               done    = 1'b1;
               if (OpCode == 6'h03) begin
                  RegWrite = 1'b1;
                  RegDst   = 2'd2;
                  MemtoReg = 2'd2;
               end
            end else if (OpCode == 6'h00 && (Funct == 6'h08 || Funct == 6'h09)) begin
               PCWrite = 1'b1;
               PCSrc   = 3'd3;
               done    = 1'b1;
               if (Funct == 6'h09) begin
                  RegWrite = 1'b1;
                  MemtoReg = 2'd2;
               end
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_branch) begin
               PCWrite = branch_cond;
               PCSrc   = 3'd1;
               done    = 1'b1;
            end else if (is_lw || is_sw) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            IorD = 1'b1;
            if (mem_ready) begin
               MemRead  = is_lw;
               MemWrite = is_sw;
               if (is_lw) state_d = S_WB;
               else       done    = 1'b1;
            end else if (timeout_hit) begin
               // The stalled request is withdrawn in the cycle the exception is taken.
               state_d = S_EXC;
               cause_d = 2'd2;
            end else begin
               MemRead  = is_lw;
               MemWrite = is_sw;
               cnt_d    = cnt_q + 8'd1;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            RegDst   = (OpCode == 6'h00) ? 2'd0 : 2'd1;
            MemtoReg = is_lw ? 2'd1 : 2'd0;
            done     = 1'b1;
         end
         S_INT, S_EXC: begin
            RegWrite = 1'b1;
            RegDst   = 2'd3;
            MemtoReg = 2'd2;
            PCWrite  = 1'b1;
            PCSrc    = (state_q == S_INT) ? 3'd4 : 3'd5;
            state_d  = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // Interrupts are only recognised at an instruction boundary.
      if (done) begin
         instr_done = 1'b1;
         if (IRQ && !ker) begin
            state_d = S_INT;
            cause_d = 2'd3;
         end else begin
            state_d = S_FETCH;
         end
      end

      if (reset) begin
         PCWrite    = 1'b0;
         PCSrc      = 3'd0;
         IorD       = 1'b0;
         IRWrite    = 1'b0;
         MemRead    = 1'b0;
         MemWrite   = 1'b0;
         RegWrite   = 1'b0;
         RegDst     = 2'd0;
         MemtoReg   = 2'd0;
         instr_done = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         cause_q <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   assign state     = state_q;
   assign exc_cause = cause_q;

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Bench for mips_multicycle_sequencer: a transaction-level model expands each
// instruction into its expected per-cycle outputs, which are compared cycle by cycle.
module tb_mips_multicycle_sequencer;

   localparam int TO = 16;
   localparam logic [2:0] FE = 3'd0, DE = 3'd1, EX = 3'd2, ME = 3'd3, WB = 3'd4,
                          IN = 3'd5, EC = 3'd6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] OpCode = '0, Funct = '0;
   logic       IRQ = 1'b0, ker = 1'b0, mem_ready = 1'b0, branch_cond = 1'b0;
   logic       PCWrite, IorD, IRWrite, MemRead, MemWrite, RegWrite, instr_done;
   logic [2:0] PCSrc, state;
   logic [1:0] RegDst, MemtoReg, exc_cause;
   logic [13:0] strobes;

   mips_multicycle_sequencer #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .IRQ(IRQ), .ker(ker),
      .mem_ready(mem_ready), .branch_cond(branch_cond), .PCWrite(PCWrite), .PCSrc(PCSrc),
      .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .state(state),
      .exc_cause(exc_cause), .instr_done(instr_done)
   );

   always #5 clk = ~clk;

   assign strobes = {PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, RegWrite,
                     RegDst, MemtoReg, instr_done};

   typedef struct {
      logic [5:0]  op, fn;
      logic        mrdy, bc, irq, ker;
      logic [18:0] exp;
   } cyc_t;

   cyc_t       q[$];
   logic [1:0] m_cause = 2'd0;
   logic [5:0] cur_op, cur_fn;
   logic       cur_bc;
   int         irq_mode;   // 0 random, 1 irq unmasked, 2 irq masked, 3 no irq
   int         n_checks = 0, n_pass = 0;

   function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'h00) return fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27], 6'h2a};
      return op inside {[6'h01:6'h0c], 6'h0f, 6'h23, 6'h2b};
   endfunction

   task automatic push(input logic [2:0] st, input logic pcw, input logic [2:0] src,
                       input logic iord, input logic irw, input logic mrd, input logic mwr,
                       input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
                       input logic dn, input int mrdy);
      cyc_t c;
      c.op   = cur_op;
      c.fn   = cur_fn;
      c.bc   = cur_bc;
      c.mrdy = (mrdy < 0) ? 1'($urandom) : 1'(mrdy);
      case (irq_mode)
         1: begin c.irq = 1'b1; c.ker = 1'b0; end
         2: begin c.irq = 1'b1; c.ker = 1'b1; end
         3: begin c.irq = 1'b0; c.ker = 1'($urandom); end
         default: begin c.irq = ($urandom_range(0, 3) == 0); c.ker = 1'($urandom); end
      endcase
      c.exp = {st, pcw, src, iord, irw, mrd, mwr, rw, rd, m2r, m_cause, dn};
      q.push_back(c);
   endtask

   task automatic idle(input logic [2:0] st);
      push(st, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, -1);
   endtask

   task automatic take_exc(input logic [1:0] cause);
      m_cause = cause;
      push(EC, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd2, 1'b0, -1);
   endtask

   task automatic finish_instr();
      cyc_t last;
      last = q[$];
      if (last.irq && !last.ker) begin
         m_cause = 2'd3;
         push(IN, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd2, 1'b0, -1);
      end
   endtask

   // nwait cycles without mem_ready; the TO-th consecutive one is a timeout.
   task automatic wait_phase(input logic [2:0] st, input logic iord, input logic mrd,
                             input logic mwr, input int nwait, output bit to);
      to = 1'b0;
      for (int k = 1; k <= nwait; k++) begin
         if (k == TO) begin
            push(st, 1'b0, 3'd0, iord, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
            to = 1'b1;
            return;
         end
         push(st, 1'b0, 3'd0, iord, 1'b0, mrd, mwr, 1'b0, 2'd0, 2'd0, 1'b0, 0);
      end
   endtask

   task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input int fwait,
                            input int mwait, input logic bc);
      bit   to;
      logic lw, sw, br;
      cur_op = op; cur_fn = fn; cur_bc = bc;
      lw = (op == 6'h23);
      sw = (op == 6'h2b);
      br = (op == 6'h01) || (op >= 6'h04 && op <= 6'h07);
      wait_phase(FE, 1'b0, 1'b1, 1'b0, fwait, to);
      if (to) begin take_exc(2'd2); return; end
      push(FE, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1);
      if (!legal(op, fn)) begin idle(DE); take_exc(2'd1); return; end
      if (op == 6'h02 || op == 6'h03) begin
         push(DE, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, (op == 6'h03), (op == 6'h03) ? 2'd2 : 2'd0,
              (op == 6'h03) ? 2'd2 : 2'd0, 1'b1, -1);
         finish_instr(); return;
      end
      if (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) begin
         push(DE, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, (fn == 6'h09), 2'd0,
              (fn == 6'h09) ? 2'd2 : 2'd0, 1'b1, -1);
         finish_instr(); return;
      end
      idle(DE);
      if (br) begin
         push(EX, bc, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, -1);
         finish_instr(); return;
      end
      idle(EX);
      if (lw || sw) begin
         wait_phase(ME, 1'b1, lw, sw, mwait, to);
         if (to) begin take_exc(2'd2); return; end
         push(ME, 1'b0, 3'd0, 1'b1, 1'b0, lw, sw, 1'b0, 2'd0, 2'd0, sw, 1);
         if (sw) begin finish_instr(); return; end
         push(WB, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b1, -1);
         finish_instr(); return;
      end
      push(WB, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (op == 6'h00) ? 2'd0 : 2'd1, 2'd0, 1'b1, -1);
      finish_instr();
   endtask

   task automatic drive_cycle(input cyc_t c, output logic [18:0] obs);
      @(negedge clk);
      reset = 1'b0; OpCode = c.op; Funct = c.fn; IRQ = c.irq; ker = c.ker;
      mem_ready = c.mrdy; branch_cond = c.bc;
      #1;
      obs = {state, PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, RegWrite,
             RegDst, MemtoReg, exc_cause, instr_done};
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; OpCode = 6'h23; mem_ready = 1'b1; IRQ = 1'b1; ker = 1'b0; branch_cond = 1'b1;
      #1;
      n_checks++;
      if (strobes !== 14'd0) $display("FAIL reset_strobes: got %h expected 0", strobes);
      else n_pass++;
      @(negedge clk); #1;
      n_checks++;
      if ({state, exc_cause, strobes} !== 19'd0)
         $display("FAIL reset_state: state %0d cause %0d strobes %h expected all 0", state, exc_cause, strobes);
      else n_pass++;
      m_cause = 2'd0;
   endtask

   task automatic test_directed_paths();
      cyc_t c; logic [18:0] obs; int idx = 0;
      irq_mode = 3;
      gen_instr(6'h00, 6'h20, 0, 0, 1'b0);   // add: 4 cycles
      gen_instr(6'h08, 6'h15, 1, 0, 1'b0);   // addi with one fetch wait
      gen_instr(6'h23, 6'h00, 0, 3, 1'b0);   // lw, mem_ready late by 3
      gen_instr(6'h04, 6'h00, 0, 0, 1'b0);   // beq not taken
      gen_instr(6'h04, 6'h00, 0, 0, 1'b1);   // beq taken
      gen_instr(6'h02, 6'h00, 0, 0, 1'b0);   // j
      gen_instr(6'h03, 6'h00, 0, 0, 1'b0);   // jal
      gen_instr(6'h00, 6'h08, 0, 0, 1'b0);   // jr
      gen_instr(6'h00, 6'h09, 0, 0, 1'b0);   // jalr
      gen_instr(6'h2b, 6'h00, 2, 1, 1'b0);   // sw
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, obs); idx++;
         n_checks++;
         if (obs !== c.exp) $display("FAIL paths cycle %0d: got %05h expected %05h", idx, obs, c.exp);
         else n_pass++;
      end
   endtask

   task automatic test_undefined();
      cyc_t c; logic [18:0] obs; int idx = 0;
      irq_mode = 2;                          // exception is taken even in kernel mode
      gen_instr(6'h3f, 6'h00, 0, 0, 1'b0);
      gen_instr(6'h00, 6'h01, 0, 0, 1'b0);
      gen_instr(6'h10, 6'h20, 0, 0, 1'b0);
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, obs); idx++;
         n_checks++;
         if (obs !== c.exp) $display("FAIL undefined cycle %0d: got %05h expected %05h", idx, obs, c.exp);
         else n_pass++;
      end
   endtask

   task automatic test_irq();
      cyc_t c; logic [18:0] obs; int idx = 0;
      irq_mode = 1; gen_instr(6'h00, 6'h20, 0, 0, 1'b0);   // unmasked -> INT
      irq_mode = 2; gen_instr(6'h00, 6'h20, 0, 0, 1'b0);   // masked -> FETCH
      irq_mode = 2; gen_instr(6'h2b, 6'h00, 0, 0, 1'b0);
      irq_mode = 1; gen_instr(6'h05, 6'h00, 0, 0, 1'b1);   // INT after taken branch
      irq_mode = 1; gen_instr(6'h03, 6'h00, 0, 0, 1'b0);   // INT after jal
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, obs); idx++;
         n_checks++;
         if (obs !== c.exp) $display("FAIL irq cycle %0d: got %05h expected %05h", idx, obs, c.exp);
         else n_pass++;
      end
   endtask

   task automatic test_timeout();
      cyc_t c; logic [18:0] obs; int idx = 0;
      irq_mode = 3;
      gen_instr(6'h2b, 6'h00, 0, TO, 1'b0);       // sw times out in MEM
      gen_instr(6'h23, 6'h00, 0, TO - 1, 1'b0);   // ready on the terminal cycle wins
      gen_instr(6'h00, 6'h20, TO + 3, 0, 1'b0);   // fetch times out
      gen_instr(6'h00, 6'h20, TO - 1, 0, 1'b0);
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, obs); idx++;
         n_checks++;
         if (obs !== c.exp) $display("FAIL timeout cycle %0d: got %05h expected %05h", idx, obs, c.exp);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      cyc_t c; logic [18:0] obs; int idx = 0;
      irq_mode = 3;
      gen_instr(6'h23, 6'h00, 0, 10, 1'b0);
      for (int i = 0; i < 5; i++) begin        // up to the second stalled MEM cycle
         c = q.pop_front(); drive_cycle(c, obs); idx++;
         n_checks++;
         if (obs !== c.exp) $display("FAIL reset_mid cycle %0d: got %05h expected %05h", idx, obs, c.exp);
         else n_pass++;
      end
      q.delete();
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1; IRQ = 1'b1; ker = 1'b0;
      #1;
      n_checks++;
      if (strobes !== 14'd0) $display("FAIL reset_mid_strobes: got %h expected 0", strobes);
      else n_pass++;
      m_cause = 2'd0;
      gen_instr(6'h00, 6'h22, 0, 0, 1'b0);     // first cycle must be FETCH with cause 0
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, obs); idx++;
         n_checks++;
         if (obs !== c.exp) $display("FAIL reset_mid cycle %0d: got %05h expected %05h", idx, obs, c.exp);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      cyc_t c; logic [18:0] obs; int idx = 0;
      logic [5:0] op, fn; int sel, fw, mw;
      irq_mode = 0;
      for (int n = 0; n < 80; n++) begin
         sel = $urandom_range(0, 9);
         op = 6'h00; fn = 6'h00;
         if (sel <= 2) begin
            do fn = 6'($urandom); while (!legal(6'h00, fn));
         end else if (sel == 3) begin
            do begin op = 6'($urandom); fn = 6'($urandom); end while (legal(op, fn));
         end else begin
            do op = 6'($urandom_range(1, 63)); while (!legal(op, 6'h00));
            fn = 6'($urandom);
         end
         fw = ($urandom_range(0, 15) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 3);
         mw = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 4);
         gen_instr(op, fn, fw, mw, 1'($urandom));
      end
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, obs); idx++;
         n_checks++;
         if (obs !== c.exp) $display("FAIL random cycle %0d: got %05h expected %05h", idx, obs, c.exp);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_directed_paths();
      test_undefined();
      test_irq();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
